// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - two-stage VGA test-pattern colour pipeline (optional border: VGA_PATTERN_BORDER_EN)
module vga_pattern_gen #(
    parameter int BOX_SIZE   = 32,
    parameter int STEP       = 2,
    parameter int CHECK_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       draw,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [1:0] mode,
    output logic [7:0] rgb,
    output logic       hs_out,
    output logic       vs_out,
    output logic [7:0] frame_cnt
);

    localparam logic [9:0]  LX     = 10'(640 - BOX_SIZE);
    localparam logic [9:0]  LY     = 10'(480 - BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);

    // Frame-rate state: active pattern, box position and direction (1 = moving towards 0)
    logic [1:0] active_mode;
    logic [9:0] box_x, box_y;
    logic       dir_x, dir_y;

    // Stage 1 registers
    logic       s1_draw, s1_hs, s1_vs;
    logic [7:0] s1_x;
    logic [2:0] s1_bar;
    logic       s1_hit, s1_chk;
`ifdef VGA_PATTERN_BORDER_EN
    logic       s1_border;
    logic       border_c;
`endif

    logic       frame_tick;
    logic [2:0] bar_c;
    logic       hit_c, chk_c;
    logic [10:0] next_x, next_y;
    logic [7:0] colour;

    // One axis of box motion; returns {new_dir, new_pos}. Compare before subtract so no underflow.
    function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir_neg,
                                              input logic [9:0] limit);
        logic [10:0] sum;
        sum = {1'b0, pos} + STEP_W;
        if (!dir_neg) begin
            if (sum >= {1'b0, limit}) return {1'b1, limit};
            else                      return {1'b0, sum[9:0]};
        end else begin
            if (pos <= STEP_W[9:0])   return {1'b0, 10'd0};
            else                      return {1'b1, pos - STEP_W[9:0]};
        end
    endfunction

    // Colour-bar palette, left to right
    function automatic logic [7:0] bar_colour(input logic [2:0] bar);
        case (bar)
            3'd0:    return 8'hFF;
            3'd1:    return 8'hFC;
            3'd2:    return 8'h1F;
            3'd3:    return 8'h1C;
            3'd4:    return 8'hE3;
            3'd5:    return 8'hE0;
            3'd6:    return 8'h03;
            default: return 8'h00;
        endcase
    endfunction

    assign frame_tick = (x == 10'd0) && (y == 10'd480);
    assign next_x     = step_axis(box_x, dir_x, LX);
    assign next_y     = step_axis(box_y, dir_y, LY);

    // Stage-1 pattern decode from the raw counters
    always_comb begin
        bar_c = 3'd7;
        if      (x < 10'd80)  bar_c = 3'd0;
        else if (x < 10'd160) bar_c = 3'd1;
        else if (x < 10'd240) bar_c = 3'd2;
        else if (x < 10'd320) bar_c = 3'd3;
        else if (x < 10'd400) bar_c = 3'd4;
        else if (x < 10'd480) bar_c = 3'd5;
        else if (x < 10'd560) bar_c = 3'd6;
        hit_c = ({1'b0, x} >= {1'b0, box_x}) && ({1'b0, x} < ({1'b0, box_x} + BOX_W)) &&
                ({1'b0, y} >= {1'b0, box_y}) && ({1'b0, y} < ({1'b0, box_y} + BOX_W));
        chk_c = x[CHECK_LOG2] ^ y[CHECK_LOG2];
`ifdef VGA_PATTERN_BORDER_EN
        border_c = (x == 10'd0) || (x == 10'd639) || (y == 10'd0) || (y == 10'd479);
`endif
    end

    // Per-frame state updates on the first blanking line
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= 8'd0;
            active_mode <= 2'd0;
            box_x       <= 10'd0;
            box_y       <= 10'd0;
            dir_x       <= 1'b0;
            dir_y       <= 1'b0;
        end else if (frame_tick) begin
            frame_cnt   <= frame_cnt + 8'd1;
            active_mode <= mode;
            {dir_x, box_x} <= next_x;
            {dir_y, box_y} <= next_y;
        end
    end

    // Stage 1: register syncs, draw flag and decoded pattern bits
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_draw <= 1'b0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s1_x    <= 8'd0;
            s1_bar  <= 3'd0;
            s1_hit  <= 1'b0;
            s1_chk  <= 1'b0;
`ifdef VGA_PATTERN_BORDER_EN
            s1_border <= 1'b0;
`endif
        end else begin
            s1_draw <= draw;
            s1_hs   <= hs_in;
            s1_vs   <= vs_in;
            s1_x    <= x[7:0];
            s1_bar  <= bar_c;
            s1_hit  <= hit_c;
            s1_chk  <= chk_c;
`ifdef VGA_PATTERN_BORDER_EN
            s1_border <= border_c;
`endif
        end
    end

    // Stage-2 colour select with blanking last so it always wins
    always_comb begin
        colour = 8'h00;
        case (active_mode)
            2'd0:    colour = bar_colour(s1_bar);
            2'd1:    colour = s1_chk ? 8'hFF : 8'h00;
            2'd2:    colour = s1_hit ? 8'hE0 : 8'h03;
            default: colour = s1_x + frame_cnt;
        endcase
`ifdef VGA_PATTERN_BORDER_EN
        if (s1_border) colour = 8'hFF;
`endif
        if (!s1_draw) colour = 8'h00;
    end

    // Stage 2: registered colour and syncs
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb    <= 8'h00;
            hs_out <= 1'b1;
            vs_out <= 1'b1;
        end else begin
            rgb    <= colour;
            hs_out <= s1_hs;
            vs_out <= s1_vs;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - scoreboard bench for vga_pattern_gen
module tb_vga_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hs_in = 1'b1, vs_in = 1'b1, draw = 1'b0;
    logic [9:0] x = 10'd700, y = 10'd10;
    logic [1:0] mode = 2'd0;
    logic [7:0] rgb, frame_cnt;
    logic       hs_out, vs_out;

    vga_pattern_gen dut (
        .clk(clk), .rst(rst), .hs_in(hs_in), .vs_in(vs_in), .draw(draw),
        .x(x), .y(y), .mode(mode), .rgb(rgb), .hs_out(hs_out), .vs_out(vs_out),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         due;
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        logic       use_rgb;
        string      name;
    } exp_t;
    exp_t sbq[$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whose output cycle has arrived
    always @(negedge clk) begin : mon
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            if (e.due < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation missed at cycle %0d (due %0d)", e.name, cyc, e.due);
            end else begin
                if (e.use_rgb) check8({e.name, " rgb"}, rgb, e.rgb);
                check8({e.name, " hs"}, {7'd0, hs_out}, {7'd0, e.hs});
                check8({e.name, " vs"}, {7'd0, vs_out}, {7'd0, e.vs});
            end
        end
    end

    task automatic pix(input int px, input int py, input logic d, input logic h, input logic v,
                       input logic use_rgb, input logic [7:0] exp_rgb, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        x = 10'(px); y = 10'(py); draw = d; hs_in = h; vs_in = v;
        e.due = cyc + 2; e.rgb = exp_rgb; e.hs = h; e.vs = v; e.use_rgb = use_rgb; e.name = name;
        sbq.push_back(e);
    endtask

    task automatic vis(input int px, input int py, input logic [7:0] exp_rgb, input string name);
        pix(px, py, 1'b1, 1'b1, 1'b1, 1'b1, exp_rgb, name);
    endtask

    task automatic ticks(input int n);
        repeat (n) pix(0, 480, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "tick");
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            x = 10'd700; y = 10'd10; draw = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        end
    endtask

    task automatic check_frame(input logic [7:0] exp, input string name);
        idle(1);
        @(negedge clk);
        check8(name, frame_cnt, exp);
    endtask

    task automatic do_reset();
        idle(3);
        @(posedge clk);
        #1;
        rst = 1'b1; x = 10'd100; y = 10'd16; draw = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check8("reset rgb", rgb, 8'h00);
        check8("reset hs_out", {7'd0, hs_out}, 8'd1);
        check8("reset vs_out", {7'd0, vs_out}, 8'd1);
        check8("reset frame_cnt", frame_cnt, 8'd0);
        rst = 1'b0; draw = 1'b0; x = 10'd700; y = 10'd10; hs_in = 1'b1; vs_in = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Colour bars and boundaries
        mode = 2'd0;
        ticks(1);
        vis(79, 10, 8'hFF, "bar x79");
        vis(80, 10, 8'hFC, "bar x80");
        vis(159, 10, 8'hFC, "bar x159");
        vis(160, 10, 8'h1F, "bar x160");
        vis(320, 10, 8'hE3, "bar x320");
        vis(400, 10, 8'hE0, "bar x400");
        vis(639, 10, 8'h00, "bar x639");
        pix(700, 10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "bar blank");
        check_frame(8'd1, "frame_cnt after 1 tick");

        // Mode change mid-frame must wait for the tick
        mode = 2'd1;
        vis(100, 200, 8'hFC, "latch y200");
        vis(100, 300, 8'hFC, "latch y300");
        vis(0, 479, 8'hFF, "latch y479");
        ticks(1);
        vis(16, 0, 8'hFF, "checker 16,0");
        vis(16, 16, 8'h00, "checker 16,16");
        vis(100, 300, 8'h00, "checker 100,300");

        // Edge pixels in checker mode
`ifdef VGA_PATTERN_BORDER_EN
        vis(0, 100, 8'hFF, "edge 0,100");
`else
        vis(0, 100, 8'h00, "edge 0,100");
`endif
        vis(639, 100, 8'hFF, "edge 639,100");
        vis(100, 479, 8'hFF, "edge 100,479");
        vis(1, 1, 8'h00, "edge 1,1");

        // Reset mid-line, then syncs track inputs two clocks late
        do_reset();
        pix(700, 10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "sync a");
        pix(700, 10, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "sync b");
        pix(700, 10, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "sync c");
        pix(700, 10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, "sync d");

        // Gradient and frame counter wrap
        mode = 2'd3;
        ticks(5);
        check_frame(8'd5, "frame_cnt 5");
        vis(250, 10, 8'hFF, "grad x250");
        vis(251, 10, 8'h00, "grad x251");
        ticks(250);
        check_frame(8'd255, "frame_cnt 255");
        ticks(1);
        check_frame(8'd0, "frame_cnt wrap");
        vis(250, 10, 8'hFA, "grad x250 fc0");

        // Bouncing box
        do_reset();
        mode = 2'd2;
        ticks(224);
        vis(448, 448, 8'hE0, "box224 corner");
        vis(447, 448, 8'h03, "box224 left");
        vis(479, 470, 8'hE0, "box224 inside");
        vis(480, 448, 8'h03, "box224 right");
        vis(448, 447, 8'h03, "box224 above");
        ticks(80);
        vis(608, 288, 8'hE0, "box304 corner");
        vis(607, 288, 8'h03, "box304 left");
        vis(638, 318, 8'hE0, "box304 inside");
        vis(608, 320, 8'h03, "box304 below");
        ticks(1);
        vis(606, 286, 8'hE0, "box305 corner");
        vis(605, 286, 8'h03, "box305 left");
        vis(638, 286, 8'h03, "box305 right");

        idle(4);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Pixel-colour stage directly downstream of the 640x480@60 VGA timing generator.
- Consumes the generator's x/y counters, draw flag and active-low hs/vs.
- Produces registered 8-bit RRRGGGBB colour with hs/vs delayed to stay pixel-aligned.
- Provides four test patterns, one of them a bouncing box animated once per frame, for board bring-up.

Parameters:
BOX_SIZE, 32, box edge length in pixels (1..479)
STEP, 2, box displacement per frame in pixels on each axis (1..BOX_SIZE)
CHECK_LOG2, 4, checkerboard square size is 2^CHECK_LOG2 pixels (1..8)

Ports:
clk  input  1  pixel clock, same clock as the timing generator
rst  input  1  synchronous, active-high reset
hs_in  input  1  horizontal sync from timing generator, active low
vs_in  input  1  vertical sync from timing generator, active low
draw  input  1  visible-area flag (x<640 && y<480)
x  input  10  horizontal pixel counter, 0..799
y  input  10  vertical line counter, 0..524
mode  input  2  requested pattern select, asynchronous to frames
rgb  output  8  pixel colour {R[2:0],G[2:0],B[1:0]}, registered
hs_out  output  1  hs_in delayed to match rgb, active low
vs_out  output  1  vs_in delayed to match rgb, active low
frame_cnt  output  8  completed-frame counter, wraps 255->0

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. All state updates on posedge clk.
- Reset values: rgb=8'h00, hs_out=1, vs_out=1, frame_cnt=0, active mode=0, box_x=0, box_y=0, dir_x=+, dir_y=+. All pipeline registers are cleared (draw stage=0, syncs=1).
- Pipeline: 2 stages, fixed latency of 2 clocks for every input, including hs/vs. Inputs sampled at cycle N appear on rgb/hs_out/vs_out at the edge ending cycle N+2.
  - Stage 1 registers x, y, draw, hs, vs and the pattern-specific decode (bar index, box hit, checker bit).
  - Stage 2 registers the final colour and syncs.
- Blanking: when staged draw=0, rgb=8'h00 regardless of mode.
- Frame tick: asserted on the single cycle where input x==0 && y==480 (first blanking line).
  - frame_cnt increments (mod 256).
  - The active mode is loaded from the mode input. Mode changes at any other time are ignored until the next tick, so no frame is torn.
  - Box position updates.
- Mode 0, colour bars: bar = x/80 via comparisons, 8 bars, colours in order FF, FC, 1F, 1C, E3, E0, 03, 00. Boundaries: x=79 -> bar0, x=80 -> bar1, x=639 -> bar7.
- Mode 1, checkerboard: rgb = (x[CHECK_LOG2]^y[CHECK_LOG2]) ? FF : 00.
- Mode 2, bouncing box: rgb = E0 if box_x<=x<box_x+BOX_SIZE and box_y<=y<box_y+BOX_SIZE, else 03.
- Mode 3, gradient: rgb = x[7:0] + frame_cnt, 8-bit wrap, no saturation.
- Box motion at each frame tick, per axis, with limits LX=640-BOX_SIZE and LY=480-BOX_SIZE:
  - Moving +: if pos+STEP >= limit, set pos=limit and flip dir to -; else pos += STEP.
  - Moving -: if pos <= STEP, set pos=0 and flip dir to +; else pos -= STEP.
  - Arithmetic is 10-bit unsigned; comparisons are done before subtraction, so no underflow.
  - Box updates regardless of the active mode.
- Reset mid-frame: outputs take reset values on the next edge. Pipeline contents are discarded, and the first post-reset valid rgb appears 2 clocks after rst deasserts.
- Inputs are trusted and not range-checked. x>799 or y>524 produce a defined but unspecified colour, and the frame tick does not fire.

Optional Feature:
- Macro: VGA_PATTERN_BORDER_EN.
- Defined: in every mode, visible pixels with x==0, x==639, y==0 or y==479 output rgb=FF, overriding the pattern. Latency is unchanged.
- Undefined: no border logic; edge pixels show the pattern colour.

Test Plan:
- Reset: hold rst 3 cycles mid-line -> rgb=00, hs_out=1, vs_out=1, frame_cnt=0. After release, hs_out/vs_out track hs_in/vs_in exactly 2 clocks late.
- Colour bars: mode=0 across one tick, drive y=10 and x=79, 80, 639 -> rgb FF, FC, 00 two clocks later. x=700 (draw=0) -> rgb=00.
- Mode latching: mode=0, switch to 1 mid-frame at y=200 -> rows 200..479 stay bars. After the tick at (0,480), next frame at x=16, y=0 -> rgb=FF; x=16, y=16 -> rgb=00.
- Box bounce (BOX_SIZE=32, STEP=2):
  - After 304 ticks box_x=LX=608 with dir_x flipped.
  - At 305 ticks box_x=606.
  - box_y reaches 448 at tick 224 and reverses.
  - Mode 2 at (box_x, box_y) -> E0; at (box_x+32, box_y) -> 03.
- Gradient/wrap: mode=3, run 256 ticks -> frame_cnt wraps 255->0. With frame_cnt=5, at x=250 -> rgb=8'hFF; at x=251 -> rgb=8'h00.
- Border (VGA_PATTERN_BORDER_EN defined), mode=1 -> (0,100)=FF, (639,100)=FF, (100,479)=FF, (1,1) follows checker=00. Rebuild with the macro undefined -> (0,100)=00 (checker).
